// File: rtl/dac_cmd_sequencer_if.sv
// rtl/dac_cmd_sequencer_if.sv - UART byte streams and DAC control bundle for the command sequencer
interface dac_cmd_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_send;
    logic [1:0] dac_control;
    logic [7:0] dac_freq;
    logic       rx_drop;

    // Sequencer side: consumes Rx bytes and Tx busy, drives replies and DAC words.
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_busy,
        output tx_data,
        output tx_send,
        output dac_control,
        output dac_freq,
        output rx_drop
    );

    // Surrounding side: UART receiver/transmitter and DAC engine.
    modport master (
        output rx_data,
        output rx_valid,
        output tx_busy,
        input  tx_data,
        input  tx_send,
        input  dac_control,
        input  dac_freq,
        input  rx_drop
    );
endinterface

// File: rtl/dac_cmd_sequencer.sv
// rtl/dac_cmd_sequencer.sv - ASCII command parser driving DAC control/frequency with one-byte UART replies
module dac_cmd_sequencer #(
    parameter logic [7:0] FREQ_DEFAULT  = 8'd108,
    parameter int         FREQ_MIN      = 1,
    parameter int         DIGIT_TIMEOUT = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    dac_cmd_sequencer_if.slave   bus
);

    localparam int            TW         = $clog2(DIGIT_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DIGIT_TIMEOUT - 1);
    localparam logic [9:0]    FREQ_LOW   = 10'(FREQ_MIN);

    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FREQ,
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t        state, state_n;
    logic [1:0]    control, control_n;
    logic [7:0]    freq, freq_n;
    logic [7:0]    tx_data, tx_data_n;
    logic          tx_send, tx_send_n;
    logic          rx_drop, rx_drop_n;
    logic [9:0]    acc, acc_n;
    logic [1:0]    cnt, cnt_n;
    logic [TW-1:0] timer, timer_n;
    logic [1:0]    wait_cnt, wait_cnt_n;

    logic          do_reply;
    logic [7:0]    reply_byte;
    logic          is_digit;
    logic [9:0]    acc_mul;

    // acc is at most 99 when a new digit is accepted, so acc*10+digit stays below 1000.
    assign acc_mul  = {acc[6:0], 3'b000} + {acc[8:0], 1'b0} + {6'd0, bus.rx_data[3:0]};
    assign is_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);

    // Next-state and output logic for command parsing and reply handshaking.
    always_comb begin
        state_n    = state;
        control_n  = control;
        freq_n     = freq;
        tx_data_n  = tx_data;
        tx_send_n  = 1'b0;
        rx_drop_n  = rx_drop;
        acc_n      = acc;
        cnt_n      = cnt;
        timer_n    = timer;
        wait_cnt_n = wait_cnt;
        do_reply   = 1'b0;
        reply_byte = CH_E;

        case (state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        8'h73: begin
                            control_n = 2'b01;
                            do_reply  = 1'b1;
                            reply_byte = CH_K;
                        end
                        8'h70: begin
                            do_reply = 1'b1;
                            if (control == 2'b01) begin
                                control_n  = 2'b10;
                                reply_byte = CH_K;
                            end
                        end
                        8'h78: begin
                            control_n  = 2'b00;
                            do_reply   = 1'b1;
                            reply_byte = CH_K;
                        end
                        8'h3F: begin
                            do_reply   = 1'b1;
                            reply_byte = {6'b001100, control};
                        end
                        8'h66: begin
                            acc_n   = '0;
                            cnt_n   = '0;
                            timer_n = '0;
                            state_n = ST_FREQ;
                        end
                        CH_CR, CH_LF: begin
                        end
                        default: begin
                            do_reply = 1'b1;
                        end
                    endcase
                end
            end

            ST_FREQ: begin
                if (bus.rx_valid) begin
                    timer_n = '0;
                    if (is_digit) begin
                        if (cnt == 2'd3) begin
                            do_reply = 1'b1;
                        end else begin
                            acc_n = acc_mul;
                            cnt_n = cnt + 2'd1;
                        end
                    end else if (bus.rx_data == CH_CR || bus.rx_data == CH_LF) begin
                        do_reply = 1'b1;
                        if (cnt != 2'd0 && acc <= 10'd255 && acc >= FREQ_LOW) begin
                            freq_n     = acc[7:0];
                            reply_byte = CH_K;
                        end
                    end else begin
                        do_reply = 1'b1;
                    end
                end else if (timer == TIMER_LAST) begin
                    do_reply = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end

            ST_SEND: begin
                if (bus.rx_valid) begin
                    rx_drop_n = 1'b1;
                end
                if (!bus.tx_busy) begin
                    tx_send_n  = 1'b1;
                    wait_cnt_n = '0;
                    state_n    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.rx_valid) begin
                    rx_drop_n = 1'b1;
                end
                if (bus.tx_busy || wait_cnt == 2'd3) begin
                    state_n = ST_IDLE;
                end else begin
                    wait_cnt_n = wait_cnt + 2'd1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (do_reply) begin
            tx_data_n = reply_byte;
            state_n   = ST_SEND;
        end
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            control  <= 2'b00;
            freq     <= FREQ_DEFAULT;
            tx_data  <= 8'h00;
            tx_send  <= 1'b0;
            rx_drop  <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            timer    <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            control  <= control_n;
            freq     <= freq_n;
            tx_data  <= tx_data_n;
            tx_send  <= tx_send_n;
            rx_drop  <= rx_drop_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            timer    <= timer_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    assign bus.tx_data     = tx_data;
    assign bus.tx_send     = tx_send;
    assign bus.dac_control = control;
    assign bus.dac_freq    = freq;
    assign bus.rx_drop     = rx_drop;

endmodule
